// File: rtl/dm_result_dumper_pkg.sv
// Shared definitions for the DM result dumper: FSM state encodings and the
// default end-of-test address/code and result window used by RTL and bench.
package dumper_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_RUN   = 3'd0;
   localparam state_t ST_ISSUE = 3'd1;
   localparam state_t ST_WAIT  = 3'd2;
   localparam state_t ST_SEND  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;
   localparam state_t ST_TOUT  = 3'd5;

   localparam int          DEF_ADDR_W       = 14;
   localparam logic [13:0] DEF_SIM_END_ADDR = 14'h3fff;
   localparam logic [31:0] DEF_SIM_END_CODE = 32'hffff_ffff;
   localparam logic [13:0] DEF_TEST_START   = 14'h2000;
   localparam int          DEF_NUM_WORDS    = 64;
   localparam int          DEF_MAX_CYCLES   = 100000;

endpackage

// File: rtl/dm_result_dumper_if.sv
// Result word stream leaving the dumper: valid/ready handshake plus the word,
// its offset from the window start and the running XOR checksum.
interface dm_result_dumper_if #(
   parameter int ADDR_W = 14
) ();

   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic [ADDR_W-1:0] out_index;
   logic [31:0]       out_csum;

   modport master (
      output out_valid,
      output out_data,
      output out_index,
      output out_csum,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_index,
      input  out_csum,
      output out_ready
   );

endinterface

// File: rtl/dm_result_dumper_watchdog.sv
// Cycle watchdog: counts enabled cycles and flags the cycle in which the count
// reaches MAX_CYCLES-1; the expired flag is sticky. MAX_CYCLES=0 disables it.
module sim_watchdog #(
   parameter int MAX_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic hit,
   output logic expired
);

   localparam logic [31:0] LIMIT = 32'(MAX_CYCLES - 1);

   logic [31:0] count;

   assign hit = (MAX_CYCLES != 0) && en && (count == LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         expired <= 1'b0;
      end else begin
         if (en) begin
            count <= count + 32'd1;
         end
         if (hit) begin
            expired <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dm_result_dumper.sv
// Snoops CPU stores for the end-of-test code, then halts the CPU, takes over the
// DM read port and streams the result window out over a valid/ready port.
module dm_result_dumper
   import dumper_pkg::*;
#(
   parameter int                ADDR_W       = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] SIM_END_ADDR = DEF_SIM_END_ADDR,
   parameter logic [31:0]       SIM_END_CODE = DEF_SIM_END_CODE,
   parameter logic [ADDR_W-1:0] TEST_START   = DEF_TEST_START,
   parameter int                NUM_WORDS    = DEF_NUM_WORDS,
   parameter int                MAX_CYCLES   = DEF_MAX_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [3:0]                cpu_dm_we,
   input  logic [ADDR_W-1:0]         cpu_dm_addr,
   input  logic [31:0]               cpu_dm_wdata,
   output logic                      cpu_halt,
   output logic                      dm_own,
   output logic                      dm_re,
   output logic [ADDR_W-1:0]         dm_addr,
   input  logic [31:0]               dm_rdata,
   dm_result_dumper_if.master        out_if,
   output logic                      done,
   output logic                      timeout
);

   localparam int                LAST_ADDR = int'(TEST_START) + NUM_WORDS - 1;
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);

   // The result window must be non-empty and must not wrap past the top of DM.
   generate
      if (NUM_WORDS < 1 || LAST_ADDR > (2 ** ADDR_W) - 1) begin : g_bad_window
         $error("dm_result_dumper: result window does not fit the DM address space");
      end
   endgenerate

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] index;
   logic [ADDR_W-1:0] index_nxt;
   logic              trigger;
   logic              accept;
   logic              wd_en;
   logic              wd_hit;

   assign trigger = (cpu_dm_we == 4'hf) && (cpu_dm_addr == SIM_END_ADDR) &&
                    (cpu_dm_wdata == SIM_END_CODE);
   assign accept  = (state == ST_SEND) && out_if.out_ready;

   // Masking the enable with the trigger lets a same-cycle trigger beat expiry.
   assign wd_en   = (state == ST_RUN) && !trigger;

   sim_watchdog #(
      .MAX_CYCLES (MAX_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (wd_en),
      .hit     (wd_hit),
      .expired (timeout)
   );

   always_comb begin
      state_nxt = state;
      index_nxt = index;
      case (state)
         ST_RUN: begin
            if (trigger) begin
               state_nxt = ST_ISSUE;
            end else if (wd_hit) begin
               state_nxt = ST_TOUT;
            end
         end
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_SEND;
         ST_SEND: begin
            if (accept) begin
               index_nxt = index + ADDR_W'(1);
               state_nxt = (index == LAST_IDX) ? ST_DONE : ST_ISSUE;
            end
         end
         ST_DONE:  state_nxt = ST_DONE;
         ST_TOUT:  state_nxt = ST_TOUT;
         default:  state_nxt = ST_RUN;
      endcase
   end

   // Outputs are decoded from the next state so they are all registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_RUN;
         index            <= '0;
         cpu_halt         <= 1'b0;
         dm_own           <= 1'b0;
         dm_re            <= 1'b0;
         dm_addr          <= '0;
         out_if.out_valid <= 1'b0;
         out_if.out_data  <= '0;
         out_if.out_csum  <= '0;
         done             <= 1'b0;
      end else begin
         state            <= state_nxt;
         index            <= index_nxt;
         cpu_halt         <= (state_nxt != ST_RUN);
         dm_own           <= (state_nxt != ST_RUN);
         dm_re            <= (state_nxt == ST_ISSUE);
         dm_addr          <= (state_nxt == ST_ISSUE) ? (TEST_START + index_nxt) : '0;
         out_if.out_valid <= (state_nxt == ST_SEND);
         done             <= (state_nxt == ST_DONE);
         if (state == ST_WAIT) begin
            out_if.out_data <= dm_rdata;
         end
         if (accept) begin
            out_if.out_csum <= out_if.out_csum ^ out_if.out_data;
         end
      end
   end

   assign out_if.out_index = index;

endmodule

// File: tb/tb_dm_result_dumper.sv
// Bench for dm_result_dumper: DM model, scoreboard of expected result words and
// directed scenarios for trigger qualification, back-pressure, reset and watchdog.
`timescale 1ns/1ps
module tb_dm_result_dumper;
   import dumper_pkg::*;

   localparam int ADDR_W    = 14;
   localparam int NUM_WORDS = 64;
   localparam int WD_MAX    = 20;

   typedef struct packed {
      logic [31:0]       data;
      logic [ADDR_W-1:0] index;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic              rst_n;
   logic [3:0]        cpu_dm_we;
   logic [ADDR_W-1:0] cpu_dm_addr;
   logic [31:0]       cpu_dm_wdata;
   logic              cpu_halt;
   logic              dm_own;
   logic              dm_re;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_rdata;
   logic              done;
   logic              timeout;
   dm_result_dumper_if #(.ADDR_W(ADDR_W)) outIf ();

   logic              wdRstN;
   logic [3:0]        wdWe;
   logic [ADDR_W-1:0] wdAddrIn;
   logic [31:0]       wdWdata;
   logic              wdHalt;
   logic              wdOwn;
   logic              wdRe;
   logic [ADDR_W-1:0] wdAddr;
   logic [31:0]       wdRdata;
   logic              wdDone;
   logic              wdTimeout;
   dm_result_dumper_if #(.ADDR_W(ADDR_W)) wdIf ();

   assign wdIf.out_ready = 1'b1;

   dm_result_dumper dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cpu_dm_we    (cpu_dm_we),
      .cpu_dm_addr  (cpu_dm_addr),
      .cpu_dm_wdata (cpu_dm_wdata),
      .cpu_halt     (cpu_halt),
      .dm_own       (dm_own),
      .dm_re        (dm_re),
      .dm_addr      (dm_addr),
      .dm_rdata     (dm_rdata),
      .out_if       (outIf),
      .done         (done),
      .timeout      (timeout)
   );

   dm_result_dumper #(.MAX_CYCLES(WD_MAX)) dutWd (
      .clk          (clk),
      .rst_n        (wdRstN),
      .cpu_dm_we    (wdWe),
      .cpu_dm_addr  (wdAddrIn),
      .cpu_dm_wdata (wdWdata),
      .cpu_halt     (wdHalt),
      .dm_own       (wdOwn),
      .dm_re        (wdRe),
      .dm_addr      (wdAddr),
      .dm_rdata     (wdRdata),
      .out_if       (wdIf),
      .done         (wdDone),
      .timeout      (wdTimeout)
   );

   // Data memory: synchronous read, poison value when no read is issued.
   logic [31:0] mem [0:(1<<ADDR_W)-1];
   logic        wdReSeen = 1'b0;

   always @(posedge clk) begin
      logic [31:0] merged;
      dm_rdata <= dm_re ? mem[dm_addr] : 32'hdead_beef;
      wdRdata  <= wdRe ? mem[wdAddr] : 32'hdead_beef;
      if (wdRe) wdReSeen <= 1'b1;
      if (cpu_dm_we != 4'h0 && !cpu_halt) begin
         merged = mem[cpu_dm_addr];
         for (int b = 0; b < 4; b++)
            if (cpu_dm_we[b]) merged[8*b +: 8] = cpu_dm_wdata[8*b +: 8];
         mem[cpu_dm_addr] <= merged;
      end
   end

   int readyMode  = 0;
   int readyPhase = 0;

   always @(posedge clk) begin
      #1;
      readyPhase = (readyPhase + 1) % 3;
      outIf.out_ready = (readyMode == 0) || (readyPhase == 0);
   end

   exp_t        expQ[$];
   logic [31:0] modelCsum = 32'h0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] we, input logic [ADDR_W-1:0] addr,
                                input logic [31:0] wdata);
      cpu_dm_we    = we;
      cpu_dm_addr  = addr;
      cpu_dm_wdata = wdata;
      @(posedge clk);
      #1;
      cpu_dm_we    = 4'h0;
      cpu_dm_addr  = '0;
      cpu_dm_wdata = '0;
   endtask

   task automatic pushExpected();
      for (int i = 0; i < NUM_WORDS; i++)
         expQ.push_back('{data: 32'(i * 3), index: ADDR_W'(i)});
   endtask

   // Monitor: scoreboard pop on accept, hold-stability and read-address checks.
   logic              prevValid = 1'b0;
   logic              prevReady = 1'b0;
   logic              prevRe    = 1'b0;
   logic [31:0]       prevData  = 32'h0;
   logic [ADDR_W-1:0] prevIndex = '0;
   int                issueCnt  = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prevValid = 1'b0;
         prevReady = 1'b0;
         prevRe    = 1'b0;
         issueCnt  = 0;
         modelCsum = 32'h0;
      end else begin
         if (prevValid && !prevReady) begin
            checkOutput("hold_valid", 32'(outIf.out_valid), 1);
            checkOutput("hold_data", outIf.out_data, prevData);
            checkOutput("hold_index", 32'(outIf.out_index), 32'(prevIndex));
         end
         if (dm_re) begin
            checkOutput("re_single_cycle", 32'(prevRe), 0);
            checkOutput("dm_addr", 32'(dm_addr), 32'(DEF_TEST_START) + 32'(issueCnt));
            issueCnt++;
         end
         if (outIf.out_valid && outIf.out_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_word: got index %0d, expected no word", outIf.out_index);
            end else begin
               e = expQ.pop_front();
               checkOutput("word_data", outIf.out_data, e.data);
               checkOutput("word_index", 32'(outIf.out_index), 32'(e.index));
               checkOutput("csum_running", outIf.out_csum, modelCsum);
               modelCsum = modelCsum ^ e.data;
            end
         end
         prevValid = outIf.out_valid;
         prevReady = outIf.out_ready;
         prevRe    = dm_re;
         prevData  = outIf.out_data;
         prevIndex = outIf.out_index;
      end
   end

   initial begin
      int          n;
      int          validCycle;
      int          lastCycle;
      int          doneCycle;
      logic [31:0] expCsum;

      for (int a = 0; a < (1 << ADDR_W); a++)
         mem[a] = (a >= 32'h2000) ? 32'((a - 32'h2000) * 3) : 32'h0;
      expCsum = 32'h0;
      for (int i = 0; i < NUM_WORDS; i++) expCsum = expCsum ^ 32'(i * 3);

      rst_n = 1'b0;  wdRstN = 1'b0;
      cpu_dm_we = 4'h0;  cpu_dm_addr = '0;  cpu_dm_wdata = '0;
      wdWe = 4'h0;  wdAddrIn = '0;  wdWdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_cpu_halt", 32'(cpu_halt), 0);
      checkOutput("rst_dm_own", 32'(dm_own), 0);
      checkOutput("rst_dm_re", 32'(dm_re), 0);
      checkOutput("rst_dm_addr", 32'(dm_addr), 0);
      checkOutput("rst_out_valid", 32'(outIf.out_valid), 0);
      checkOutput("rst_out_data", outIf.out_data, 0);
      checkOutput("rst_out_index", 32'(outIf.out_index), 0);
      checkOutput("rst_out_csum", outIf.out_csum, 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_timeout", 32'(timeout), 0);
      rst_n = 1'b1;

      // Near-miss stores must not trigger.
      repeat (5) @(posedge clk);
      #1;
      applyStimulus(4'h1, 14'h3fff, 32'hffff_ffff);
      applyStimulus(4'hf, 14'h3fff, 32'hffff_fffe);
      applyStimulus(4'hf, 14'h3ffe, 32'hffff_ffff);
      applyStimulus(4'h7, 14'h3fff, 32'hffff_ffff);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("no_trig_halt", 32'(cpu_halt), 0);
      checkOutput("no_trig_own", 32'(dm_own), 0);
      checkOutput("no_trig_valid", 32'(outIf.out_valid), 0);

      // Run 1: end code near cycle 50, sink always ready.
      repeat (35) @(posedge clk);
      #1;
      pushExpected();
      applyStimulus(4'hf, DEF_SIM_END_ADDR, DEF_SIM_END_CODE);
      checkOutput("halt_after_trig", 32'(cpu_halt), 1);
      checkOutput("own_after_trig", 32'(dm_own), 1);
      n = 0;  validCycle = 0;  lastCycle = 0;  doneCycle = 0;
      while (n < 400 && doneCycle == 0) begin
         @(negedge clk);
         n++;
         if (validCycle == 0 && outIf.out_valid) validCycle = n;
         if (outIf.out_valid && outIf.out_ready && outIf.out_index == 63) lastCycle = n;
         if (done) doneCycle = n;
      end
      checkOutput("first_valid_cycle", 32'(validCycle), 3);
      checkOutput("last_accept_cycle", 32'(lastCycle), 192);
      checkOutput("done_cycle", 32'(doneCycle), 193);
      checkOutput("run1_queue_empty", 32'(expQ.size()), 0);
      checkOutput("run1_csum", outIf.out_csum, expCsum);
      checkOutput("run1_done_valid", 32'(outIf.out_valid), 0);
      checkOutput("run1_done_halt", 32'(cpu_halt), 1);
      checkOutput("run1_done_own", 32'(dm_own), 1);
      checkOutput("run1_timeout", 32'(timeout), 0);

      // A second end code in DONE is ignored.
      applyStimulus(4'hf, DEF_SIM_END_ADDR, DEF_SIM_END_CODE);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("done_sticky", 32'(done), 1);
      checkOutput("done_no_valid", 32'(outIf.out_valid), 0);
      checkOutput("done_csum_kept", outIf.out_csum, expCsum);

      // Run 2: throttled sink, reset while word 10 is being offered.
      rst_n = 1'b0;
      readyMode = 1;
      @(posedge clk);
      #1;
      expQ.delete();
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      pushExpected();
      applyStimulus(4'hf, DEF_SIM_END_ADDR, DEF_SIM_END_CODE);
      n = 0;
      while (n < 1000 && !(outIf.out_valid && outIf.out_index == 10)) begin
         @(negedge clk);
         n++;
      end
      checkOutput("reached_word10", 32'(outIf.out_index), 10);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_halt", 32'(cpu_halt), 0);
      checkOutput("abort_own", 32'(dm_own), 0);
      checkOutput("abort_re", 32'(dm_re), 0);
      checkOutput("abort_valid", 32'(outIf.out_valid), 0);
      checkOutput("abort_data", outIf.out_data, 0);
      checkOutput("abort_index", 32'(outIf.out_index), 0);
      checkOutput("abort_csum", outIf.out_csum, 0);
      checkOutput("abort_done", 32'(done), 0);
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Run 3: clean restart with the throttled sink.
      repeat (3) @(posedge clk);
      #1;
      pushExpected();
      applyStimulus(4'hf, DEF_SIM_END_ADDR, DEF_SIM_END_CODE);
      n = 0;
      while (n < 2000 && !done) begin
         @(negedge clk);
         n++;
      end
      checkOutput("run3_done", 32'(done), 1);
      checkOutput("run3_queue_empty", 32'(expQ.size()), 0);
      checkOutput("run3_csum", outIf.out_csum, expCsum);
      checkOutput("run3_timeout", 32'(timeout), 0);

      // Watchdog expiry with no end code.
      @(posedge clk);
      #1;
      wdRstN = 1'b1;
      n = 0;
      while (n < 100 && !wdTimeout) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("timeout_edge", 32'(n), WD_MAX);
      repeat (5) @(posedge clk);
      #1;
      checkOutput("tout_sticky", 32'(wdTimeout), 1);
      checkOutput("tout_halt", 32'(wdHalt), 1);
      checkOutput("tout_valid", 32'(wdIf.out_valid), 0);
      checkOutput("tout_no_reads", 32'(wdReSeen), 0);
      checkOutput("tout_done", 32'(wdDone), 0);

      // Trigger on the last watchdog cycle wins over expiry.
      wdRstN = 1'b0;
      @(posedge clk);
      #1;
      wdRstN = 1'b1;
      repeat (WD_MAX - 1) @(posedge clk);
      #1;
      checkOutput("pre_trig_timeout", 32'(wdTimeout), 0);
      wdWe = 4'hf;  wdAddrIn = DEF_SIM_END_ADDR;  wdWdata = DEF_SIM_END_CODE;
      @(posedge clk);
      #1;
      wdWe = 4'h0;  wdAddrIn = '0;  wdWdata = '0;
      checkOutput("race_timeout", 32'(wdTimeout), 0);
      checkOutput("race_halt", 32'(wdHalt), 1);
      checkOutput("race_re", 32'(wdRe), 1);
      n = 0;
      while (n < 400 && !wdDone) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("race_done", 32'(wdDone), 1);
      checkOutput("race_timeout_end", 32'(wdTimeout), 0);
      checkOutput("race_csum", wdIf.out_csum, expCsum);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
